nor3_checker: RTL and testbench
===============================

Name: nor3_checker

Overview:
- Clocked response checker for the 3-input NOR cell. It is the observing end of the stimulus/DUT pair.
- It samples the three NOR inputs and the NOR output, waits for them to settle, and compares the output against the expected value ~(a|b|c).
- It counts mismatches and records which of the 8 input combinations have been exercised.
- It raises done when full input coverage is reached with zero errors. It is instantiated in benches alongside nor3 for the coverage-automation flow.

Parameters:
- ERR_W, 8, width of the saturating mismatch counter.
- SETTLE, 2, consecutive stable cycles required before a vector is checked; legal range 1..15.

Ports:
- clk  input  1  sampling clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  checking enable; level-sensitive
- clr  input  1  synchronous clear of coverage, errors and FSM; has priority over en
- a  input  1  NOR input a, as driven to the DUT
- b  input  1  NOR input b
- c  input  1  NOR input c
- d  input  1  DUT NOR output
- cov_map  output  8  bit i set once vector {a,b,c}==i has been checked
- cov_full  output  1  cov_map==8'hFF
- err_cnt  output  ERR_W  mismatch count, saturating at all-ones
- err  output  1  sticky; set on first mismatch
- done  output  1  high in DONE state
- busy  output  1  high in RUN state

Behaviour:
- Reset (rst_n=0, async) clears all registers:
  - cov_map=0, cov_full=0, err_cnt=0, err=0, done=0, busy=0
  - state=IDLE, stab=0
  - input sync regs vec_q=0, d_q=0; previous-vector reg vec_p=0
- Input stage, every edge: vec_q<={a,b,c}, d_q<=d, vec_p<=vec_q.
- Settle counter stab (4 bits):
  - Held at 0 while state==IDLE.
  - Otherwise: vec_q!=vec_p -> stab<=0; else if stab<SETTLE -> stab<=stab+1.
- Check strobe chk = (state!=IDLE) && (vec_q==vec_p) && (stab==SETTLE-1).
  - Fires exactly once per stable window.
  - A vector held longer is not rechecked.
  - A vector changing before settling is never checked.
- On chk, at that same edge:
  - cov_map[vec_q]<=1.
  - Mismatch if d_q !== ~(|vec_q). X or Z on d counts as a mismatch.
  - On mismatch: err_cnt<=err_cnt+1 unless already all-ones; err<=1.
- Latency: an input change registered at edge k is checked at edge k+SETTLE+1. Outputs update on that edge.
- FSM, states IDLE, RUN, DONE, FAIL:
  - Any state: clr=1 -> IDLE with cov_map, err_cnt, err, stab cleared. Input regs are not cleared.
  - Any state: en=0 (clr=0) -> IDLE. Counters and cov_map are retained.
  - IDLE, en=1 -> RUN.
  - RUN -> FAIL on a chk with mismatch.
  - RUN -> DONE on a chk that makes cov_map 8'hFF with no mismatch and err==0.
  - DONE -> FAIL on any later mismatch. Checking continues in DONE and FAIL.
  - FAIL is held until en=0 or clr.
  - Simultaneous: a chk that completes coverage and also mismatches goes to FAIL.
- Outputs are registered: done=(state==DONE), busy=(state==RUN), cov_full registered from the next cov_map.
- Re-entering RUN after en toggles resumes with retained coverage. If cov_map is already full and err==0, the next clean chk goes to DONE.
- Reset asserted mid-window aborts the pending check. No partial update occurs.

Optional Feature:
- Macro NOR3_CHK_LASTERR_EN.
- Defined: adds output port last_err[3:0] (reset 0), loaded with {vec_q,d_q} on every mismatch chk and cleared by clr.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Clean sweep: SETTLE=2, ideal NOR model; a/b/c toggle every 200/100/50 cycles (clk period 1), en=1.
  - Expect cov_map=8'hFF after the vector 111 window, then done=1, err_cnt=0, err=0.
- Fault injection: force d=1 while {a,b,c}=3'b010.
  - Expect err=1, err_cnt=1, busy=0, state FAIL; cov_map bit 2 set.
  - Hold the same vector 100 cycles: err_cnt stays 1, because there is no recheck.
- Glitch rejection: change vector for 1 cycle (< SETTLE) then return.
  - Expect no cov_map bit for the glitch vector and no err_cnt change.
- Saturation: ERR_W=2, stuck-at-1 d across 8 vectors.
  - Expect err_cnt to stick at 3.
- Control: clr pulse in DONE -> cov_map=0, err_cnt=0, IDLE.
  - Drop en mid-RUN, then reassert: coverage retained.
  - rst_n low mid-window: all outputs 0 asynchronously.
- With NOR3_CHK_LASTERR_EN: single fault at vector 3'b000 with d=0.
  - Expect last_err=4'b0000.
  - Then fault at 3'b101 with d=1: expect last_err=4'b1011.

Source files
------------

// File: rtl/nor3_checker.sv
// nor3_checker: clocked response checker for a 3-input NOR cell with coverage and error tracking
//   clk      rising-edge sampling clock
//   rst_n    asynchronous active-low reset
//   en       checking enable (level); dropping it parks the FSM in IDLE, keeping counters
//   clr      synchronous clear of coverage, errors and FSM; wins over en
//   a,b,c    NOR inputs as driven to the cell under test
//   d        cell output under test
//   cov_map  bit i set once vector {a,b,c}==i has been checked
//   cov_full cov_map is all ones
//   err_cnt  saturating mismatch count
//   err      sticky mismatch flag
//   done     full coverage reached with no mismatch
//   busy     checking in progress without failure or completion
//   last_err {vector,d} of the latest mismatch; only with NOR3_CHK_LASTERR_EN defined
module nor3_checker #(
  parameter int ERR_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic [7:0]       cov_map,
  output logic             cov_full,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err,
  output logic             done,
  output logic             busy
`ifdef NOR3_CHK_LASTERR_EN
  ,
  output logic [3:0]       last_err
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;
  state_t state, nxt;
  logic [2:0] vec_q, vec_p;
  logic d_q, chk, mis;
  logic [3:0] stab;
  logic [7:0] cov_nxt;
  // chk fires once per stable window: stab passes SETTLE-1 only on its way up and then parks at SETTLE
  always_comb begin
    chk = (state != IDLE) && (vec_q == vec_p) && (stab == 4'(SETTLE - 1));
    mis = d_q !== ~(|vec_q);
    cov_nxt = cov_map | (8'd1 << vec_q);
    nxt = (clr || !en) ? IDLE :
          (state == IDLE) ? RUN :
          (chk && mis) ? FAIL :
          (state == RUN && chk && cov_nxt == 8'hFF && !err) ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      vec_p <= '0;
      d_q <= 1'b0;
      stab <= '0;
      state <= IDLE;
      cov_map <= '0;
      cov_full <= 1'b0;
      err_cnt <= '0;
      err <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
`ifdef NOR3_CHK_LASTERR_EN
      last_err <= '0;
`endif
    end else begin
      vec_q <= {a, b, c};
      d_q <= d;
      vec_p <= vec_q;
      state <= nxt;
      done <= nxt == DONE;
      busy <= nxt == RUN;
      if (clr) begin
        stab <= '0;
        cov_map <= '0;
        cov_full <= 1'b0;
        err_cnt <= '0;
        err <= 1'b0;
`ifdef NOR3_CHK_LASTERR_EN
        last_err <= '0;
`endif
      end else begin
        stab <= (state == IDLE || vec_q != vec_p) ? 4'd0 : (stab < 4'(SETTLE)) ? stab + 4'd1 : stab;
        if (chk && en) begin
          cov_map <= cov_nxt;
          cov_full <= cov_nxt == 8'hFF;
          if (mis) begin
            err_cnt <= &err_cnt ? err_cnt : err_cnt + 1'b1;
            err <= 1'b1;
`ifdef NOR3_CHK_LASTERR_EN
            last_err <= {vec_q, d_q};
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_nor3_checker.sv
// tb_nor3_checker: directed scoreboard bench for nor3_checker
module tb_nor3_checker;
  logic clk, rst_n, en, clr, a, b, c, d;
  logic [7:0] cov1, cov2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  logic full1, err1, done1, busy1, full2, err2, done2, busy2;
  logic [3:0] le1, le2;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    bit sel;
    string nm;
    logic [23:0] v;
  } exp_t;
  exp_t sb[$];
  exp_t x;
  logic [23:0] act;

  nor3_checker #(.ERR_W(8), .SETTLE(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c), .d(d),
    .cov_map(cov1), .cov_full(full1), .err_cnt(cnt1), .err(err1), .done(done1), .busy(busy1)
`ifdef NOR3_CHK_LASTERR_EN
    , .last_err(le1)
`endif
  );

  nor3_checker #(.ERR_W(2), .SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c), .d(1'b1),
    .cov_map(cov2), .cov_full(full2), .err_cnt(cnt2), .err(err2), .done(done2), .busy(busy2)
`ifdef NOR3_CHK_LASTERR_EN
    , .last_err(le2)
`endif
  );

`ifndef NOR3_CHK_LASTERR_EN
  assign le1 = 4'h0;
  assign le2 = 4'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", sb.size());
    $fatal(1, "timeout");
  end

  // Monitor: compares every queued expectation at the negedge of the cycle it targets
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      act = x.sel ? {cov2, 6'd0, cnt2, full2, err2, done2, busy2, 4'd0}
                  : {cov1, cnt1, full1, err1, done1, busy1, le1};
      checks++;
      if (act !== x.v) begin
        errors++;
        $display("FAIL %s: got cov=%h cnt=%h full=%b err=%b done=%b busy=%b le=%h, expected cov=%h cnt=%h full=%b err=%b done=%b busy=%b le=%h",
                 x.nm, act[23:16], act[15:8], act[7], act[6], act[5], act[4], act[3:0],
                 x.v[23:16], x.v[15:8], x.v[7], x.v[6], x.v[5], x.v[4], x.v[3:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vec(input logic [2:0] v, input logic dv, input int n);
    {a, b, c} = v;
    d = dv;
    step(n);
  endtask

  task automatic expect1(input string nm, input logic [7:0] cv, input logic [7:0] cn,
                         input logic e, input logic dn, input logic bs, input logic [3:0] le);
    exp_t t;
    t.cyc = cyc;
    t.sel = 1'b0;
    t.nm = nm;
`ifdef NOR3_CHK_LASTERR_EN
    t.v = {cv, cn, cv == 8'hFF, e, dn, bs, le};
`else
    t.v = {cv, cn, cv == 8'hFF, e, dn, bs, 4'h0};
`endif
    sb.push_back(t);
  endtask

  task automatic expect2(input string nm, input logic [7:0] cv, input logic [1:0] cn,
                         input logic e, input logic dn, input logic bs);
    exp_t t;
    t.cyc = cyc;
    t.sel = 1'b1;
    t.nm = nm;
    t.v = {cv, 6'd0, cn, cv == 8'hFF, e, dn, bs, 4'h0};
    sb.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; {a, b, c} = 3'b000; d = 1'b1;
    step(3);
    expect1("reset", 8'h00, 8'd0, 0, 0, 0, 4'h0);
    expect2("reset_sat", 8'h00, 2'd0, 0, 0, 0);
    rst_n = 1'b1;
    step(2);
    expect1("idle_en_low", 8'h00, 8'd0, 0, 0, 0, 4'h0);
    en = 1'b1;
    step(1);
    expect1("enter_run", 8'h00, 8'd0, 0, 0, 1, 4'h0);
    step(5);
    expect1("sweep0", 8'h01, 8'd0, 0, 0, 1, 4'h0);
    expect2("stuck0_clean", 8'h01, 2'd0, 0, 0, 1);
    vec(3'd1, 1'b0, 6);
    expect1("sweep1", 8'h03, 8'd0, 0, 0, 1, 4'h0);
    expect2("stuck1_fail", 8'h03, 2'd1, 1, 0, 0);
    vec(3'd2, 1'b0, 3);
    expect1("latency_before", 8'h03, 8'd0, 0, 0, 1, 4'h0);
    step(1);
    expect1("latency_at", 8'h07, 8'd0, 0, 0, 1, 4'h0);
    step(2);
    vec(3'd3, 1'b0, 6);
    expect1("sweep3", 8'h0F, 8'd0, 0, 0, 1, 4'h0);
    vec(3'd4, 1'b0, 6);
    expect1("sweep4", 8'h1F, 8'd0, 0, 0, 1, 4'h0);
    vec(3'd5, 1'b0, 6);
    expect1("sweep5", 8'h3F, 8'd0, 0, 0, 1, 4'h0);
    vec(3'd6, 1'b0, 6);
    expect1("sweep6", 8'h7F, 8'd0, 0, 0, 1, 4'h0);
    vec(3'd7, 1'b0, 6);
    expect1("sweep_done", 8'hFF, 8'd0, 0, 1, 0, 4'h0);
    expect2("saturate", 8'hFF, 2'd3, 1, 0, 0);
    step(20);
    expect1("done_hold", 8'hFF, 8'd0, 0, 1, 0, 4'h0);
    en = 1'b0;
    step(1);
    expect1("en_drop_done", 8'hFF, 8'd0, 0, 0, 0, 4'h0);
    en = 1'b1;
    step(1);
    expect1("reenter_run", 8'hFF, 8'd0, 0, 0, 1, 4'h0);
    step(2);
    expect1("redone_full", 8'hFF, 8'd0, 0, 1, 0, 4'h0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    expect1("clr_in_done", 8'h00, 8'd0, 0, 0, 0, 4'h0);
    expect2("clr_sat", 8'h00, 2'd0, 0, 0, 0);
    step(6);
    expect1("after_clr", 8'h80, 8'd0, 0, 0, 1, 4'h0);
    vec(3'd2, 1'b1, 6);
    expect1("fault_010", 8'h84, 8'd1, 1, 0, 0, 4'h5);
    step(100);
    expect1("no_recheck", 8'h84, 8'd1, 1, 0, 0, 4'h5);
    en = 1'b0;
    d = 1'b0;
    step(1);
    expect1("fail_en_drop", 8'h84, 8'd1, 1, 0, 0, 4'h5);
    en = 1'b1;
    step(6);
    expect1("resume_run", 8'h84, 8'd1, 1, 0, 1, 4'h5);
    vec(3'd5, 1'b1, 1);
    vec(3'd2, 1'b0, 6);
    expect1("glitch_reject", 8'h84, 8'd1, 1, 0, 1, 4'h5);
    vec(3'd6, 1'b0, 2);
    rst_n = 1'b0;
    expect1("async_reset", 8'h00, 8'd0, 0, 0, 0, 4'h0);
    expect2("async_reset_sat", 8'h00, 2'd0, 0, 0, 0);
    step(2);
    {a, b, c} = 3'b000;
    d = 1'b0;
    rst_n = 1'b1;
    step(8);
    expect1("lasterr_000", 8'h01, 8'd1, 1, 0, 0, 4'h0);
    vec(3'd5, 1'b1, 6);
    expect1("lasterr_101", 8'h21, 8'd2, 1, 0, 0, 4'hB);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    expect1("lasterr_clr", 8'h00, 8'd0, 0, 0, 0, 4'h0);
    step(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
